// File: rtl/stream_packet_arbiter_if.sv
`default_nettype none
// ============================================================================
// stream_packet_arbiter_if
// Source-side and sink-side stream signals shared by the packet arbiter.
// Revision: 1.0
// ============================================================================
interface stream_packet_arbiter_if #(
   parameter int T_DATA_WIDTH = 1,
   parameter int KEEP_WIDTH   = 8,
   parameter int N_SRC        = 2
);
   localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   logic [N_SRC-1:0][KEEP_WIDTH-1:0][T_DATA_WIDTH-1:0] s_data_in;
   logic [N_SRC-1:0][KEEP_WIDTH-1:0]                   s_keep_in;
   logic [N_SRC-1:0]                                   s_last_in;
   logic [N_SRC-1:0]                                   s_valid_in;
   logic [N_SRC-1:0]                                   s_ready_out;
   logic [KEEP_WIDTH-1:0][T_DATA_WIDTH-1:0]            m_data_out;
   logic [KEEP_WIDTH-1:0]                              m_keep_out;
   logic                                               m_last_out;
   logic                                               m_valid_out;
   logic                                               m_ready_in;
   logic [SRC_W-1:0]                                   m_id_out;
   logic                                               busy_out;

   // Arbiter view
   modport slave (
      input  s_data_in, s_keep_in, s_last_in, s_valid_in, m_ready_in,
      output s_ready_out, m_data_out, m_keep_out, m_last_out, m_valid_out,
             m_id_out, busy_out
   );

   // Environment view: drives the sources and the downstream ready
   modport master (
      output s_data_in, s_keep_in, s_last_in, s_valid_in, m_ready_in,
      input  s_ready_out, m_data_out, m_keep_out, m_last_out, m_valid_out,
             m_id_out, busy_out
   );
endinterface
`default_nettype wire

// File: rtl/stream_packet_arbiter.sv
`default_nettype none
// ============================================================================
// stream_packet_arbiter
// Packet-atomic round-robin arbiter: N_SRC stream sources onto one sink.
// Revision: 1.0
// ============================================================================
module stream_packet_arbiter #(
   parameter int T_DATA_WIDTH = 1,
   parameter int KEEP_WIDTH   = 8,
   parameter int N_SRC        = 2
) (
   input wire clk,
   input wire rst_n,
   stream_packet_arbiter_if.slave bus
);
   localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t                                 r_state, w_state_nxt;
   logic [SRC_W-1:0]                       r_grant, w_grant_nxt;
   logic [SRC_W-1:0]                       r_rr_ptr, w_rr_ptr_nxt;
   logic [SRC_W-1:0]                       w_sel;
   logic                                   w_sel_found;
   logic [SRC_W-1:0]                       w_src;
   logic                                   w_active;
   logic                                   w_valid;
   logic                                   w_last;
   logic                                   w_xfer;
   logic [N_SRC-1:0]                       w_ready;
   logic [KEEP_WIDTH-1:0][T_DATA_WIDTH-1:0] w_data;
   logic [KEEP_WIDTH-1:0]                  w_keep;

   function automatic logic [SRC_W-1:0] f_next_src(input logic [SRC_W-1:0] x);
      if (x == SRC_W'(N_SRC - 1)) begin
         return '0;
      end
      return x + SRC_W'(1);
   endfunction

   // First valid source at or after rr_ptr, wrapping modulo N_SRC
   always_comb begin : p_rr_search
      int idx;
      w_sel       = '0;
      w_sel_found = 1'b0;
      idx         = 0;
      for (int k = 0; k < N_SRC; k++) begin
         idx = int'(r_rr_ptr) + k;
         if (idx >= N_SRC) begin
            idx = idx - N_SRC;
         end
         for (int i = 0; i < N_SRC; i++) begin
            if (!w_sel_found && (i == idx) && bus.s_valid_in[i]) begin
               w_sel       = SRC_W'(i);
               w_sel_found = 1'b1;
            end
         end
      end
   end

   assign w_src    = (r_state == LOCK) ? r_grant : w_sel;
   assign w_active = rst_n && ((r_state == LOCK) || w_sel_found);

   always_comb begin : p_mux
      w_valid = 1'b0;
      w_last  = 1'b0;
      w_data  = '0;
      w_keep  = '0;
      w_ready = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (w_active && (w_src == SRC_W'(i))) begin
            w_ready[i] = bus.m_ready_in;
            if (bus.s_valid_in[i]) begin
               w_valid = 1'b1;
               w_last  = bus.s_last_in[i];
               w_data  = bus.s_data_in[i];
               w_keep  = bus.s_keep_in[i];
            end
         end
      end
   end

   assign w_xfer = w_valid && bus.m_ready_in;

   always_comb begin : p_next
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_rr_ptr_nxt = r_rr_ptr;
      case (r_state)
         IDLE: begin
            if (w_xfer) begin
               if (w_last) begin
                  w_rr_ptr_nxt = f_next_src(w_sel);
               end else begin
                  w_state_nxt = LOCK;
                  w_grant_nxt = w_sel;
               end
            end
         end
         LOCK: begin
            if (w_xfer && w_last) begin
               w_state_nxt  = IDLE;
               w_rr_ptr_nxt = f_next_src(r_grant);
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_grant  <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_grant  <= w_grant_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
      end
   end

   // Every path above is already qualified by rst_n through w_active
   assign bus.s_ready_out = w_ready;
   assign bus.m_valid_out = w_valid;
   assign bus.m_last_out  = w_last;
   assign bus.m_data_out  = w_data;
   assign bus.m_keep_out  = w_keep;
   assign bus.m_id_out    = w_active ? w_src : '0;
   assign bus.busy_out    = rst_n && (r_state == LOCK);

endmodule
`default_nettype wire

// File: tb/tb_stream_packet_arbiter.sv
`default_nettype none
// ============================================================================
// tb_stream_packet_arbiter
// Vector table, directed corner sequences and random traffic vs. a packet model.
// Revision: 1.0
// ============================================================================
module tb_stream_packet_arbiter;
   localparam int T_DATA_WIDTH = 1;
   localparam int KEEP_WIDTH   = 8;
   localparam int N_SRC        = 2;
   localparam int SRC_W        = 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   stream_packet_arbiter_if #(.T_DATA_WIDTH(T_DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH),
                              .N_SRC(N_SRC)) bus ();
   stream_packet_arbiter #(.T_DATA_WIDTH(T_DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH),
                           .N_SRC(N_SRC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic                  mv;
      logic [SRC_W-1:0]      id;
      logic [N_SRC-1:0]      sr;
      logic                  busy;
      logic                  last;
      logic [KEEP_WIDTH-1:0] keep;
      logic [7:0]            data;
   } exp_t;

   typedef struct {
      logic [1:0] v;
      logic [1:0] l;
      logic       rdy;
      logic       mv;
      logic       id;
      logic [1:0] sr;
      logic       busy;
      logic       last;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   logic [N_SRC-1:0] in_v, in_l;
   logic             in_rdy;
   logic [7:0]       in_d [N_SRC];
   logic [7:0]       in_k [N_SRC];

   // Packet-level model: owner of an open packet (-1 = none) and next priority
   int m_lock = -1;
   int m_rr   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model_expect();
      exp_t e;
      int   owner;
      e = '{default: '0};
      owner = -1;
      if (rst_n) begin
         if (m_lock >= 0) begin
            owner  = m_lock;
            e.busy = 1'b1;
         end else begin
            for (int k = 0; k < N_SRC; k++) begin
               if (owner < 0 && in_v[(m_rr + k) % N_SRC]) owner = (m_rr + k) % N_SRC;
            end
         end
         if (owner >= 0) begin
            e.id        = SRC_W'(owner);
            e.sr[owner] = in_rdy;
            if (in_v[owner]) begin
               e.mv   = 1'b1;
               e.last = in_l[owner];
               e.data = in_d[owner];
               e.keep = in_k[owner];
            end
         end
      end
      return e;
   endfunction

   task automatic model_update();
      exp_t e;
      e = model_expect();
      if (!rst_n) begin
         m_lock = -1;
         m_rr   = 0;
      end else if (e.mv && in_rdy) begin
         if (e.last) begin
            m_lock = -1;
            m_rr   = (int'(e.id) + 1) % N_SRC;
         end else begin
            m_lock = int'(e.id);
         end
      end
   endtask

   task automatic apply_inputs();
      bus.s_valid_in = in_v;
      bus.s_last_in  = in_l;
      bus.m_ready_in = in_rdy;
      for (int i = 0; i < N_SRC; i++) begin
         bus.s_data_in[i] = in_d[i];
         bus.s_keep_in[i] = in_k[i];
      end
   endtask

   task automatic check_all(input exp_t e);
      chk("m_valid", bus.m_valid_out, e.mv);
      chk("m_id",    bus.m_id_out,    e.id);
      chk("s_ready", bus.s_ready_out, e.sr);
      chk("busy",    bus.busy_out,    e.busy);
      chk("m_last",  bus.m_last_out,  e.last);
      chk("m_keep",  bus.m_keep_out,  e.keep);
      chk("m_data",  bus.m_data_out,  e.data);
   endtask

   // Called just after a rising edge; checks mid-cycle, advances one clock
   task automatic step(input logic use_vec, input exp_t ve);
      apply_inputs();
      #3;
      if (use_vec) check_all(ve);
      else         check_all(model_expect());
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic mstep();
      exp_t dummy;
      dummy = '{default: '0};
      step(1'b0, dummy);
   endtask

   vec_t vt[$];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      exp_t e;
      rst_n  = 1'b0;
      in_v   = '0;
      in_l   = '0;
      in_rdy = 1'b0;
      in_d[0] = 8'h5A; in_d[1] = 8'hC3;
      in_k[0] = 8'h0F; in_k[1] = 8'hF0;

      // Rows: v, l, rdy | mv, id, sr, busy, last  (starts from reset: IDLE, rr=0)
      vt.push_back('{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0});
      vt.push_back('{2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0});
      vt.push_back('{2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0});
      vt.push_back('{2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1});
      vt.push_back('{2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0});
      vt.push_back('{2'b11, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1});
      vt.push_back('{2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0});
      vt.push_back('{2'b11, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1});
      vt.push_back('{2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0});
      vt.push_back('{2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0});
      vt.push_back('{2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0});
      vt.push_back('{2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1});
      vt.push_back('{2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1});
      vt.push_back('{2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1});
      vt.push_back('{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0});

      // Reset state, with sources active so the output gating is exercised
      @(posedge clk); #1;
      in_v = 2'b11; in_rdy = 1'b1;
      mstep();
      mstep();
      in_v = '0;
      rst_n = 1'b1;

      foreach (vt[r]) begin
         in_v   = vt[r].v;
         in_l   = vt[r].l;
         in_rdy = vt[r].rdy;
         e.mv   = vt[r].mv;
         e.id   = vt[r].id;
         e.sr   = vt[r].sr;
         e.busy = vt[r].busy;
         e.last = vt[r].last;
         e.data = vt[r].mv ? in_d[vt[r].id] : 8'h00;
         e.keep = vt[r].mv ? in_k[vt[r].id] : 8'h00;
         step(1'b1, e);
      end

      // src1 locked, then drops valid for 4 cycles while src0 waits
      in_rdy = 1'b1;
      in_v = 2'b10; in_l = 2'b00; mstep();
      in_v = 2'b01;
      for (int i = 0; i < 4; i++) mstep();
      in_v = 2'b11; in_l = 2'b10; mstep();

      // Sink stalls for 5 cycles on a locked beat
      in_v = 2'b01; in_l = 2'b00; mstep();
      in_d[0] = 8'h96; in_k[0] = 8'h3C; in_rdy = 1'b0;
      for (int i = 0; i < 5; i++) mstep();
      in_rdy = 1'b1; in_l = 2'b01; mstep();

      // Back-to-back single-beat packets from both sources
      in_k[0] = 8'h07; in_k[1] = 8'h07; in_v = 2'b11; in_l = 2'b11;
      for (int i = 0; i < 4; i++) mstep();

      // Reset asserted in the middle of a src1 packet
      in_v = 2'b10; in_l = 2'b00; mstep();
      in_v = 2'b11; rst_n = 1'b0;
      mstep();
      mstep();
      rst_n = 1'b1; mstep();
      in_l = 2'b11; mstep();

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         rst_n  = ($urandom_range(0, 99) != 0);
         in_rdy = ($urandom_range(0, 9) < 7);
         for (int i = 0; i < N_SRC; i++) begin
            in_v[i] = ($urandom_range(0, 3) != 0);
            in_l[i] = ($urandom_range(0, 2) == 0);
            in_d[i] = 8'($urandom);
            in_k[i] = 8'($urandom);
         end
         mstep();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
